// File: rtl/tx_fifo_wr_arb.sv
// Round-robin arbiter that grants one requester at a time ownership of the TX FIFO
// write port for a whole packet, with a mid-packet idle timeout.
module tx_fifo_wr_arb #(
  parameter int unsigned N_REQ   = 4,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic                    wr_clk,
  input  logic                    wr_rst,
  input  logic [N_REQ-1:0]        req_valid,
  input  logic [N_REQ*DATA_W-1:0] req_data,
  input  logic [N_REQ-1:0]        req_last,
  output logic [N_REQ-1:0]        req_ready,
  output logic                    fifo_wr_en,
  output logic [DATA_W-1:0]       fifo_wr_data,
  input  logic                    fifo_full,
  input  logic                    fifo_almost_full,
  output logic [N_REQ-1:0]        grant,
  output logic                    busy,
  output logic                    timeout_err,
  output logic [15:0]             pkt_cnt
);

  localparam int unsigned IdxW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic [0:0] {StIdle, StBurst} state_e;

  state_e            state_q, state_d;
  logic [N_REQ-1:0]  grant_q, grant_d;
  logic [IdxW-1:0]   owner_q, owner_d;
  logic [IdxW-1:0]   last_owner_q, last_owner_d;
  logic [7:0]        idle_cnt_q, idle_cnt_d;
  logic [15:0]       pkt_cnt_q, pkt_cnt_d;
  logic              timeout_q, timeout_d;

  logic [DATA_W-1:0] data_arr [N_REQ];
  logic              owner_valid;
  logic              owner_last;
  logic              accept;
  logic [7:0]        idle_inc;
  logic              win_found;
  logic [IdxW-1:0]   win_idx;
  int unsigned       cand;
  logic [IdxW-1:0]   cand_idx;

  always_comb begin
    for (int unsigned i = 0; i < N_REQ; i++) begin
      data_arr[i] = req_data[i*DATA_W +: DATA_W];
    end
  end

  assign owner_valid = req_valid[owner_q];
  assign owner_last  = req_last[owner_q];
  assign accept      = (state_q == StBurst) && owner_valid && !fifo_full;
  assign idle_inc    = idle_cnt_q + 8'd1;

  // Round-robin search starting one past the previous owner, ascending with wrap.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = 0;
    cand_idx  = '0;
    for (int unsigned k = 1; k <= N_REQ; k++) begin
      cand     = (32'(last_owner_q) + k) % N_REQ;
      cand_idx = IdxW'(cand);
      if (!win_found && req_valid[cand_idx]) begin
        win_found = 1'b1;
        win_idx   = cand_idx;
      end
    end
  end

  always_ff @(posedge wr_clk or posedge wr_rst) begin
    if (wr_rst) begin
      state_q      <= StIdle;
      grant_q      <= '0;
      owner_q      <= '0;
      last_owner_q <= IdxW'(N_REQ - 1);
      idle_cnt_q   <= '0;
      pkt_cnt_q    <= '0;
      timeout_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      idle_cnt_q   <= idle_cnt_d;
      pkt_cnt_q    <= pkt_cnt_d;
      timeout_q    <= timeout_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    idle_cnt_d   = idle_cnt_q;
    pkt_cnt_d    = pkt_cnt_q;
    timeout_d    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (win_found && !fifo_almost_full) begin
          state_d    = StBurst;
          owner_d    = win_idx;
          grant_d    = N_REQ'(1) << win_idx;
          idle_cnt_d = '0;
        end
      end
      StBurst: begin
        if (accept) begin
          idle_cnt_d = '0;
          if (owner_last) begin
            state_d      = StIdle;
            grant_d      = '0;
            last_owner_d = owner_q;
            pkt_cnt_d    = pkt_cnt_q + 16'd1;
          end
        end else if (!owner_valid) begin
          // Stalls on fifo_full with valid high are not idleness.
          if (idle_inc == 8'(TIMEOUT)) begin
            state_d      = StIdle;
            grant_d      = '0;
            last_owner_d = owner_q;
            idle_cnt_d   = '0;
            timeout_d    = 1'b1;
          end else begin
            idle_cnt_d = idle_inc;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    busy         = (state_q == StBurst);
    req_ready    = '0;
    fifo_wr_en   = 1'b0;
    fifo_wr_data = data_arr[owner_q];
    if (busy) begin
      req_ready  = fifo_full ? '0 : grant_q;
      fifo_wr_en = accept;
    end
  end

  assign grant       = grant_q;
  assign timeout_err = timeout_q;
  assign pkt_cnt     = pkt_cnt_q;

endmodule

// File: tb/tb_tx_fifo_wr_arb.sv
// Bench for tx_fifo_wr_arb: directed scenarios plus random traffic, all checked every
// cycle against a packet-level reference model.
module tb_tx_fifo_wr_arb;

  localparam int NR = 4;
  localparam int DW = 32;
  localparam int TO = 16;

  logic            wr_clk = 1'b0;
  logic            wr_rst;
  logic [NR-1:0]   req_valid;
  logic [NR*DW-1:0] req_data;
  logic [NR-1:0]   req_last;
  logic [NR-1:0]   req_ready;
  logic            fifo_wr_en;
  logic [DW-1:0]   fifo_wr_data;
  logic            fifo_full;
  logic            fifo_almost_full;
  logic [NR-1:0]   grant;
  logic            busy;
  logic            timeout_err;
  logic [15:0]     pkt_cnt;

  tx_fifo_wr_arb #(
    .N_REQ  (NR),
    .DATA_W (DW),
    .TIMEOUT(TO)
  ) dut (
    .wr_clk          (wr_clk),
    .wr_rst          (wr_rst),
    .req_valid       (req_valid),
    .req_data        (req_data),
    .req_last        (req_last),
    .req_ready       (req_ready),
    .fifo_wr_en      (fifo_wr_en),
    .fifo_wr_data    (fifo_wr_data),
    .fifo_full       (fifo_full),
    .fifo_almost_full(fifo_almost_full),
    .grant           (grant),
    .busy            (busy),
    .timeout_err     (timeout_err),
    .pkt_cnt         (pkt_cnt)
  );

  always #5 wr_clk = ~wr_clk;

  int errors = 0;
  int checks = 0;

  // Reference model: who owns the port (-1 = nobody), previous owner, idle run, packets.
  int          m_owner;
  int          m_last;
  int          m_idle;
  logic [15:0] m_pkt;
  logic        m_to;

  int acc_idx;
  int wen_seen;
  int to_seen;
  int nb;
  int bc [NR];
  int order [$];
  logic [NR-1:0] prev_grant;
  bit  full_pat [8] = '{0, 0, 1, 1, 1, 0, 0, 0};

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int oh_idx(input logic [NR-1:0] g);
    for (int i = 0; i < NR; i++) if (g[i]) return i;
    return -1;
  endfunction

  task automatic model_reset();
    m_owner = -1;
    m_last  = NR - 1;
    m_idle  = 0;
    m_pkt   = '0;
    m_to    = 1'b0;
  endtask

  task automatic rand_data();
    for (int i = 0; i < NR; i++) req_data[i*DW +: DW] = $urandom;
  endtask

  // One clock cycle: check outputs mid-cycle, then advance the model across the edge.
  task automatic step();
    logic [NR-1:0] eg;
    logic [NR-1:0] er;
    logic          ew;
    int            c;
    bit            to_next;
    @(negedge wr_clk);
    eg = (m_owner >= 0) ? NR'(1 << m_owner) : '0;
    er = (m_owner >= 0 && !fifo_full) ? eg : '0;
    ew = (m_owner >= 0) && req_valid[m_owner] && !fifo_full;
    chk("busy", busy, m_owner >= 0);
    chk("grant", grant, eg);
    chk("req_ready", req_ready, er);
    chk("fifo_wr_en", fifo_wr_en, ew);
    if (ew) chk("fifo_wr_data", fifo_wr_data, req_data[m_owner*DW +: DW]);
    chk("timeout_err", timeout_err, m_to);
    chk("pkt_cnt", pkt_cnt, m_pkt);
    wen_seen += int'(fifo_wr_en);
    to_seen  += int'(timeout_err);
    acc_idx = ew ? m_owner : -1;
    to_next = 0;
    if (m_owner < 0) begin
      if (req_valid != '0 && !fifo_almost_full) begin
        for (int k = 1; k <= NR; k++) begin
          c = (m_last + k) % NR;
          if (req_valid[c]) begin
            m_owner = c;
            m_idle  = 0;
            break;
          end
        end
      end
    end else if (ew) begin
      m_idle = 0;
      if (req_last[m_owner]) begin
        m_pkt++;
        m_last  = m_owner;
        m_owner = -1;
      end
    end else if (!req_valid[m_owner]) begin
      m_idle++;
      if (m_idle == TO) begin
        to_next = 1;
        m_last  = m_owner;
        m_owner = -1;
      end
    end
    m_to = to_next;
    @(posedge wr_clk);
    #1;
  endtask

  task automatic do_reset();
    wr_rst = 1'b1;
    #1;
    chk("rst_grant", grant, '0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_wr_en", fifo_wr_en, 1'b0);
    chk("rst_ready", req_ready, '0);
    chk("rst_timeout", timeout_err, 1'b0);
    chk("rst_pkt_cnt", pkt_cnt, 16'd0);
    model_reset();
    @(posedge wr_clk);
    #1;
    wr_rst = 1'b0;
  endtask

  initial begin
    wr_rst           = 1'b0;
    req_valid        = '0;
    req_last         = '0;
    req_data         = '0;
    fifo_full        = 1'b0;
    fifo_almost_full = 1'b0;
    model_reset();
    #1;
    do_reset();

    // Single requester 1, four beats.
    req_valid = 4'b0010;
    rand_data();
    step();
    chk("r35_grant", grant, 4'b0010);
    wen_seen = 0;
    for (int b = 0; b < 4; b++) begin
      req_last = (b == 3) ? 4'b0010 : 4'b0000;
      rand_data();
      step();
    end
    req_valid = '0;
    req_last  = '0;
    chk("r35_wen_count", wen_seen, 4);
    chk("r35_busy_after", busy, 1'b0);
    chk("r35_pkt_cnt", pkt_cnt, 16'd1);

    // All requesters valid, two-beat packets: round-robin order.
    do_reset();
    for (int i = 0; i < NR; i++) bc[i] = 0;
    order.delete();
    prev_grant = '0;
    req_valid  = 4'b1111;
    for (int cyc = 0; cyc < 15; cyc++) begin
      for (int i = 0; i < NR; i++) req_last[i] = (bc[i] == 1);
      rand_data();
      step();
      if (acc_idx >= 0) bc[acc_idx] = (bc[acc_idx] + 1) % 2;
      if (grant != '0 && prev_grant == '0) order.push_back(oh_idx(grant));
      prev_grant = grant;
    end
    req_valid = '0;
    req_last  = '0;
    chk("r36_n_grants", order.size(), 5);
    if (order.size() == 5) begin
      chk("r36_order0", order[0], 0);
      chk("r36_order1", order[1], 1);
      chk("r36_order2", order[2], 2);
      chk("r36_order3", order[3], 3);
      chk("r36_order4", order[4], 0);
    end

    // fifo_full held three cycles mid-packet.
    do_reset();
    req_valid = 4'b0001;
    req_data  = '0;
    step();
    wen_seen = 0;
    to_seen  = 0;
    nb       = 0;
    for (int i = 0; i < 8; i++) begin
      fifo_full         = full_pat[i];
      req_last          = (nb == 4) ? 4'b0001 : 4'b0000;
      req_data[DW-1:0]  = 32'hA000 + 32'(nb);
      step();
      if (acc_idx >= 0) nb++;
    end
    fifo_full = 1'b0;
    req_valid = '0;
    req_last  = '0;
    chk("r37_wen_count", wen_seen, 5);
    chk("r37_no_timeout", to_seen, 0);
    chk("r37_pkt_cnt", pkt_cnt, 16'd1);

    // Owner goes quiet mid-packet: timeout and hand-over.
    do_reset();
    req_valid = 4'b0001;
    rand_data();
    step();
    step();
    step();
    to_seen   = 0;
    req_valid = 4'b0100;
    for (int i = 0; i < 20; i++) begin
      rand_data();
      step();
    end
    chk("r38_timeout_pulses", to_seen, 1);
    chk("r38_grant_moved", grant, 4'b0100);
    chk("r38_pkt_cnt", pkt_cnt, 16'd0);
    req_valid = '0;

    // almost_full blocks new grants but not a running packet.
    do_reset();
    fifo_almost_full = 1'b1;
    req_valid        = 4'b1010;
    for (int i = 0; i < 5; i++) begin
      rand_data();
      step();
    end
    chk("r39_no_grant", grant, 4'b0000);
    fifo_almost_full = 1'b0;
    step();
    chk("r39_grant", grant, 4'b0010);
    fifo_almost_full = 1'b1;
    wen_seen = 0;
    nb       = 0;
    for (int i = 0; i < 3; i++) begin
      req_last = (nb == 2) ? 4'b0010 : 4'b0000;
      rand_data();
      step();
      if (acc_idx >= 0) nb++;
    end
    chk("r39_wen_count", wen_seen, 3);
    chk("r39_pkt_cnt", pkt_cnt, 16'd1);
    fifo_almost_full = 1'b0;
    req_valid        = '0;
    req_last         = '0;

    // Reset during a burst of requester 2.
    do_reset();
    req_valid = 4'b0100;
    rand_data();
    step();
    chk("r40_grant2", grant, 4'b0100);
    step();
    step();
    req_valid = 4'b0101;
    do_reset();
    step();
    chk("r40_restart", grant, 4'b0001);
    req_valid = '0;

    // Random traffic with periodic quiet windows long enough to time out.
    do_reset();
    for (int cyc = 0; cyc < 2000; cyc++) begin
      if (cyc == 1000) do_reset();
      req_valid = ((cyc % 150) >= 125) ? 4'b0000 : NR'($urandom);
      for (int i = 0; i < NR; i++) req_last[i] = ($urandom_range(0, 2) == 0);
      fifo_full        = ($urandom_range(0, 4) == 0);
      fifo_almost_full = ($urandom_range(0, 3) == 0);
      rand_data();
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
